// File: rtl/mcs51_uart_peer.sv
`default_nettype none
// ============================================================================
// Module      : mcs51_uart_peer
// Description : Far-end serial peer for the MCS-51 serial port. Receives
//               mode 1/2/3 frames on rxd_in and transmits frames on txd_out.
// Revision    : 1.0 - initial release
// ============================================================================
module mcs51_uart_peer #(
    parameter int CLKS_PER_BIT = 32,
    parameter bit NINE_BIT     = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd_in,
    output logic       txd_out,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic [7:0] tx_data,
    input  logic       tx_bit8,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       rx_bit8,
    output logic       rx_frame_err,
    output logic       rx_busy
);

    localparam int              c_TW   = $clog2(CLKS_PER_BIT);
    localparam logic [c_TW-1:0] c_FULL = c_TW'(CLKS_PER_BIT - 1);
    localparam logic [c_TW-1:0] c_HALF = c_TW'(CLKS_PER_BIT / 2 - 1);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_START = 3'd1;
    localparam logic [2:0] c_ST_DATA  = 3'd2;
    localparam logic [2:0] c_ST_BIT8  = 3'd3;
    localparam logic [2:0] c_ST_STOP  = 3'd4;

    // ------------------------------------------------------------------ RX
    logic            r_sync1;
    logic            r_rxs;
    logic [2:0]      r_rx_state;
    logic [c_TW-1:0] r_rx_cnt;
    logic [3:0]      r_rx_idx;
    logic [7:0]      r_rx_shift;
    logic            r_rx_b8;
    logic            r_rx_valid;
    logic [7:0]      r_rx_data;
    logic            r_rx_bit8;
    logic            r_rx_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1    <= 1'b1;
            r_rxs      <= 1'b1;
            r_rx_state <= c_ST_IDLE;
            r_rx_cnt   <= '0;
            r_rx_idx   <= 4'd0;
            r_rx_shift <= 8'h00;
            r_rx_b8    <= 1'b0;
            r_rx_valid <= 1'b0;
            r_rx_data  <= 8'h00;
            r_rx_bit8  <= 1'b0;
            r_rx_err   <= 1'b0;
        end else begin
            r_sync1    <= rxd_in;
            r_rxs      <= r_sync1;
            r_rx_valid <= 1'b0;
            case (r_rx_state)
                c_ST_IDLE: begin
                    if (!r_rxs) begin
                        r_rx_cnt   <= c_HALF;
                        r_rx_state <= c_ST_START;
                    end
                end
                c_ST_START: begin
                    if (r_rx_cnt == '0) begin
                        // A start bit that is high again at mid-bit was a glitch
                        if (r_rxs) begin
                            r_rx_state <= c_ST_IDLE;
                        end else begin
                            r_rx_cnt   <= c_FULL;
                            r_rx_idx   <= 4'd0;
                            r_rx_state <= c_ST_DATA;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt - 1'b1;
                    end
                end
                c_ST_DATA: begin
                    if (r_rx_cnt == '0) begin
                        r_rx_shift <= {r_rxs, r_rx_shift[7:1]};
                        r_rx_cnt   <= c_FULL;
                        if (r_rx_idx == 4'd7) begin
                            r_rx_state <= NINE_BIT ? c_ST_BIT8 : c_ST_STOP;
                        end else begin
                            r_rx_idx <= r_rx_idx + 4'd1;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt - 1'b1;
                    end
                end
                c_ST_BIT8: begin
                    if (r_rx_cnt == '0) begin
                        r_rx_b8    <= r_rxs;
                        r_rx_cnt   <= c_FULL;
                        r_rx_state <= c_ST_STOP;
                    end else begin
                        r_rx_cnt <= r_rx_cnt - 1'b1;
                    end
                end
                c_ST_STOP: begin
                    // Finish at mid-stop so a short stop bit from a fast sender is not lost
                    if (r_rx_cnt == '0) begin
                        r_rx_data  <= r_rx_shift;
                        r_rx_bit8  <= NINE_BIT & r_rx_b8;
                        r_rx_err   <= ~r_rxs;
                        r_rx_valid <= 1'b1;
                        r_rx_state <= c_ST_IDLE;
                    end else begin
                        r_rx_cnt <= r_rx_cnt - 1'b1;
                    end
                end
                default: r_rx_state <= c_ST_IDLE;
            endcase
        end
    end

    assign rx_valid     = r_rx_valid;
    assign rx_data      = r_rx_data;
    assign rx_bit8      = r_rx_bit8;
    assign rx_frame_err = r_rx_err;
    assign rx_busy      = (r_rx_state != c_ST_IDLE);

    // ------------------------------------------------------------------ TX
    logic [2:0]      r_tx_state;
    logic [c_TW-1:0] r_tx_cnt;
    logic [3:0]      r_tx_idx;
    logic [7:0]      r_tx_byte;
    logic            r_tx_b8;
    logic            r_txd;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_state <= c_ST_IDLE;
            r_tx_cnt   <= '0;
            r_tx_idx   <= 4'd0;
            r_tx_byte  <= 8'h00;
            r_tx_b8    <= 1'b0;
            r_txd      <= 1'b1;
        end else begin
            case (r_tx_state)
                c_ST_IDLE: begin
                    r_txd <= 1'b1;
                    if (tx_valid) begin
                        r_tx_byte  <= tx_data;
                        r_tx_b8    <= tx_bit8;
                        r_tx_cnt   <= c_FULL;
                        r_txd      <= 1'b0;
                        r_tx_state <= c_ST_START;
                    end
                end
                c_ST_START: begin
                    if (r_tx_cnt == '0) begin
                        r_tx_cnt   <= c_FULL;
                        r_tx_idx   <= 4'd0;
                        r_txd      <= r_tx_byte[0];
                        r_tx_state <= c_ST_DATA;
                    end else begin
                        r_tx_cnt <= r_tx_cnt - 1'b1;
                    end
                end
                c_ST_DATA: begin
                    if (r_tx_cnt == '0) begin
                        r_tx_cnt <= c_FULL;
                        if (r_tx_idx == 4'd7) begin
                            if (NINE_BIT) begin
                                r_txd      <= r_tx_b8;
                                r_tx_state <= c_ST_BIT8;
                            end else begin
                                r_txd      <= 1'b1;
                                r_tx_state <= c_ST_STOP;
                            end
                        end else begin
                            // Byte shifts right so bit 1 is always the next to go out
                            r_txd     <= r_tx_byte[1];
                            r_tx_byte <= {1'b0, r_tx_byte[7:1]};
                            r_tx_idx  <= r_tx_idx + 4'd1;
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt - 1'b1;
                    end
                end
                c_ST_BIT8: begin
                    if (r_tx_cnt == '0) begin
                        r_tx_cnt   <= c_FULL;
                        r_txd      <= 1'b1;
                        r_tx_state <= c_ST_STOP;
                    end else begin
                        r_tx_cnt <= r_tx_cnt - 1'b1;
                    end
                end
                c_ST_STOP: begin
                    if (r_tx_cnt == '0) begin
                        r_tx_state <= c_ST_IDLE;
                    end else begin
                        r_tx_cnt <= r_tx_cnt - 1'b1;
                    end
                end
                default: r_tx_state <= c_ST_IDLE;
            endcase
        end
    end

    assign txd_out  = r_txd;
    assign tx_ready = (r_tx_state == c_ST_IDLE);

endmodule
`default_nettype wire

// File: doc/mcs51_uart_peer.md
# mcs51_uart_peer

Host-side serial peer for the MCU's on-chip serial port, i.e. the far end of the TXD/RXD link. It receives asynchronous frames driven by the MCU on P3.1 (TXD) and transmits frames into the MCU on P3.0 (RXD). Framing follows serial modes 1 (10-bit) and 2/3 (11-bit with ninth bit). It is used in system-level benches and as a synthesizable bridge between the MCU and an external byte-stream host.

## Interface
- `CLKS_PER_BIT`, default 32: clock cycles per serial bit. Must be even and ≥4.
- `NINE_BIT`, default 0: 0 selects a 10-bit frame (start, 8 data, stop). 1 selects an 11-bit frame (start, 8 data, bit8, stop).
- `clk`  in  1: single clock; all logic is rising-edge.
- `reset`  in  1: synchronous, active-high reset.
- `rxd_in`  in  1: serial input, connected to the MCU `p3_out[1]`. Asynchronous.
- `txd_out`  out  1: serial output, connected to the MCU `p3_in[0]`. Idles high.
- `tx_valid`  in  1: host offers a byte.
- `tx_ready`  out  1: transmitter idle and able to accept a byte.
- `tx_data`  in  8: byte to send, LSB first.
- `tx_bit8`  in  1: ninth bit to send. Ignored when `NINE_BIT`=0.
- `rx_valid`  out  1: one-cycle pulse when a received frame completes.
- `rx_data`  out  8: received byte. Held until the next `rx_valid`.
- `rx_bit8`  out  1: received ninth bit. 0 when `NINE_BIT`=0.
- `rx_frame_err`  out  1: qualifies `rx_valid`. High when the stop bit was sampled low.
- `rx_busy`  out  1: receiver is inside a frame.

## Operation
- **Reset values:** `txd_out`=1, `tx_ready`=1, `rx_valid`=0, `rx_data`=0x00, `rx_bit8`=0, `rx_frame_err`=0, `rx_busy`=0.
- **Reset behaviour:**
  - Both FSMs go to IDLE, the bit counters clear, and the synchronizer loads 1.
  - Reset mid-frame aborts the frame with no `rx_valid`.
  - `txd_out` returns high on the cycle after reset is sampled.
- **Synchronizer:** `rxd_in` passes through a 2-flop synchronizer. All receive decisions use the synchronized value `rxs`.
- **RX FSM: RX_IDLE → RX_START → RX_DATA → (RX_BIT8 if `NINE_BIT`) → RX_STOP → RX_IDLE.**
  - RX_IDLE: when `rxs`=0, load the counter with `CLKS_PER_BIT/2-1` and go to RX_START.
  - RX_START: at counter expiry, sample `rxs`.
    - 1 (false start): return to RX_IDLE with no output.
    - 0: reload the counter with `CLKS_PER_BIT-1` and go to RX_DATA.
  - RX_DATA: sample one bit per bit period into a shift register, LSB first. After 8 samples go to RX_BIT8 or RX_STOP.
  - RX_STOP: at the mid-bit sample:
    - update `rx_data` and `rx_bit8`;
    - set `rx_frame_err` = ~`rxs`;
    - pulse `rx_valid`;
    - go to RX_IDLE immediately, without waiting for the end of the stop bit.
    - If `rxs` is still low in RX_IDLE, that low is treated as a new start edge.
  - `rx_busy` is 1 in every state except RX_IDLE.
  - No backpressure: the host must consume on the `rx_valid` cycle.
- **TX FSM: TX_IDLE → TX_START → TX_DATA → (TX_BIT8) → TX_STOP → TX_IDLE.**
  - `tx_ready` = (state == TX_IDLE).
  - A handshake occurs when `tx_valid` && `tx_ready`. On it, latch `tx_data`/`tx_bit8` and enter TX_START.
  - Each bit is driven for exactly `CLKS_PER_BIT` cycles: start bit 0, data LSB first, bit8, stop bit 1.
  - After the last stop cycle, return to TX_IDLE.
  - `tx_valid` while not ready is ignored; the offered data need not be held.
- **Counters:**
  - The bit-timer width is `$clog2(CLKS_PER_BIT)`. It counts down, and expiry is reaching 0.
  - The bit index is 4 bits and never wraps inside a frame.
- TX and RX are fully independent; simultaneous activity in both directions is allowed.

## Timing
- **TX:**
  - Handshake at cycle h → `txd_out`=0 from h+1.
  - Data bit k is driven during cycles h+1+(k+1)·`CLKS_PER_BIT` … +`CLKS_PER_BIT`-1.
  - The stop bit ends at h+F·`CLKS_PER_BIT`, where F = 10, or 11 with `NINE_BIT`.
  - `tx_ready`=1 at h+1+F·`CLKS_PER_BIT`.
  - Back-to-back frames have zero idle bits when `tx_valid` is held high.
- **RX:**
  - Let e be the first cycle `rxs`=0 while in RX_IDLE; `rxd_in` fell 2 cycles earlier.
  - The start sample is at e+`CLKS_PER_BIT/2`.
  - Bit j (start=0) is sampled at e+`CLKS_PER_BIT/2`+j·`CLKS_PER_BIT`.
  - `rx_valid` is high on the cycle after the stop sample.
- **Tolerance:** mid-bit sampling must accept a ±4% bit-rate mismatch over a full frame.

## Test plan
- **TX single byte:** `CLKS_PER_BIT`=32, `NINE_BIT`=0, send 0xA5 → `txd_out` sequence 0,1,0,1,0,0,1,0,1,1, each bit 32 cycles. `tx_ready` returns 321 cycles after the handshake.
- **RX loopback:** `txd_out` tied to `rxd_in`, send 0x3C then 0xFF back-to-back → two `rx_valid` pulses, `rx_data`=0x3C then 0xFF, `rx_frame_err`=0.
- **Nine-bit:** `NINE_BIT`=1, send 0x81 with `tx_bit8`=1 in loopback → 11-bit frame; `rx_data`=0x81, `rx_bit8`=1.
- **Glitch and frame error:**
  - Drive `rxd_in` low for 10 cycles → no `rx_valid`, `rx_busy` returns to 0.
  - Drive a frame 0x55 with the stop bit low → `rx_valid` with `rx_data`=0x55 and `rx_frame_err`=1.
- **MCU link:** `mcs51_mcu` in mode 1 transmits 0x42 on SBUF with the peer's `CLKS_PER_BIT` matched to the Timer1 rate → peer `rx_data`=0x42. Peer sends 0x17 → MCU RI=1 and SBUF reads 0x17.
- **Reset mid-frame:** assert `reset` for 1 cycle during bit 4 of both TX and RX → `txd_out`=1 next cycle, `tx_ready`=1, no `rx_valid`; a subsequent frame is received correctly.
